epb_frame_rx: RTL and testbench

//   Serial front end for the even-parity checker stage: receives one UART-style frame per

---
 rtl/epb_frame_rx.sv | 157 +++++++++++++++
 tb/tb_epb_frame_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/epb_frame_rx.sv
// Serial receiver for one start/4-data/even-parity/stop frame feeding the even-parity checker.
// Holds the last good nibble and its parity bit on a..d/epb and pulses frame_valid/frame_err.
module epb_frame_rx #(
    parameter int BIT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic epb,
    output logic frame_valid,
    output logic frame_err,
    output logic busy
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t        state_r;
    logic          rxd_meta_r;
    logic          rxd_sync_r;
    logic          rxd_s;
    logic [CW-1:0] cnt_r;
    logic [1:0]    bitn_r;
    logic [3:0]    shift_r;
    logic          par_r;
    logic [3:0]    nib_r;
    logic          epb_r;
    logic          frame_valid_r;
    logic          frame_err_r;
    logic          busy_r;

    // Two-flop synchronizer; idles high so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxd_sync_r <= rxd_meta_r;
        end
    end

    assign rxd_s = rxd_sync_r;

    // Frame FSM: bit timing, data/parity capture, stop check and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= '0;
            bitn_r        <= 2'd0;
            shift_r       <= 4'd0;
            par_r         <= 1'b0;
            nib_r         <= 4'd0;
            epb_r         <= 1'b0;
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            frame_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rxd_s == 1'b0) begin
                        state_r <= ST_START;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    // Half a bit in: a line that is high again was only a glitch
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= '0;
                        if (rxd_s == 1'b1) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                            bitn_r  <= 2'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        shift_r[bitn_r] <= rxd_s;
                        cnt_r           <= '0;
                        if (bitn_r == 2'd3) begin
                            state_r <= ST_PARITY;
                        end else begin
                            bitn_r  <= bitn_r + 2'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        par_r   <= rxd_s;
                        cnt_r   <= '0;
                        state_r <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    // Parity is passed through untouched; only the stop bit is judged here
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        if (rxd_s == 1'b1) begin
                            nib_r         <= shift_r;
                            epb_r         <= par_r;
                            frame_valid_r <= 1'b1;
                        end else begin
                            frame_err_r   <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign a           = nib_r[0];
    assign b           = nib_r[1];
    assign c           = nib_r[2];
    assign d           = nib_r[3];
    assign epb         = epb_r;
    assign frame_valid = frame_valid_r;
    assign frame_err   = frame_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_epb_frame_rx.sv
// Directed bench for epb_frame_rx: one instance at 4 clocks/bit, one at 16 clocks/bit,
// sharing clock and reset.
module tb_epb_frame_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd4 = 1'b1;
    logic rxd16 = 1'b1;

    logic a4, b4, c4, d4, epb4, fv4, fe4, busy4;
    logic a16, b16, c16, d16, epb16, fv16, fe16, busy16;

    int n_checks = 0;
    int n_fail = 0;

    int fv4_cnt = 0, fe4_cnt = 0, both4_cnt = 0, busy4_cnt = 0;
    int fv16_cnt = 0, fe16_cnt = 0, both16_cnt = 0;
    logic [3:0] log_nib [0:3];
    logic       log_par [0:3];

    always #5 clk = ~clk;

    epb_frame_rx #(.BIT_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .rxd(rxd4),
        .a(a4), .b(b4), .c(c4), .d(d4), .epb(epb4),
        .frame_valid(fv4), .frame_err(fe4), .busy(busy4)
    );

    epb_frame_rx #(.BIT_CYCLES(16)) dut16 (
        .clk(clk), .rst(rst), .rxd(rxd16),
        .a(a16), .b(b16), .c(c16), .d(d16), .epb(epb16),
        .frame_valid(fv16), .frame_err(fe16), .busy(busy16)
    );

    // Pulse monitor: counts high cycles, so a pulse wider than one cycle shows up as extra counts
    always @(negedge clk) begin
        if (fv4 === 1'b1) fv4_cnt++;
        if (fe4 === 1'b1) fe4_cnt++;
        if (fv4 === 1'b1 && fe4 === 1'b1) both4_cnt++;
        if (busy4 === 1'b1) busy4_cnt++;
        if (fv16 === 1'b1) begin
            if (fv16_cnt < 4) begin
                log_nib[fv16_cnt] = {d16, c16, b16, a16};
                log_par[fv16_cnt] = epb16;
            end
            fv16_cnt++;
        end
        if (fe16 === 1'b1) fe16_cnt++;
        if (fv16 === 1'b1 && fe16 === 1'b1) both16_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bits(input int which, input logic [6:0] bits, input int nbits, input int bc);
        for (int i = 0; i < nbits; i++) begin
            if (which == 4) rxd4 = bits[i];
            else            rxd16 = bits[i];
            repeat (bc) @(negedge clk);
        end
    endtask

    task automatic send(input int which, input logic [3:0] data, input logic par,
                        input logic stop, input int bc);
        drive_bits(which, {stop, par, data, 1'b0}, 7, bc);
        if (which == 4) rxd4 = 1'b1;
        else            rxd16 = 1'b1;
    endtask

    initial begin
        int busy_before;

        // Reset
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check("rst_nib4", {d4, c4, b4, a4}, 4'h0);
        check("rst_epb4", epb4, 1'b0);
        check("rst_fv4", fv4, 1'b0);
        check("rst_fe4", fe4, 1'b0);
        check("rst_busy4", busy4, 1'b0);
        check("rst_nib16", {d16, c16, b16, a16}, 4'h0);
        check("rst_busy16", busy16, 1'b0);
        idle(50);
        check("idle_fv4_cnt", fv4_cnt, 0);
        check("idle_fe4_cnt", fe4_cnt, 0);
        check("idle_busy4_cnt", busy4_cnt, 0);
        check("idle_fv16_cnt", fv16_cnt, 0);

        // Good frame 1011, epb=1
        send(4, 4'b1011, 1'b1, 1'b1, 4);
        idle(10);
        check("f1_fv_cnt", fv4_cnt, 1);
        check("f1_fe_cnt", fe4_cnt, 0);
        check("f1_nib", {d4, c4, b4, a4}, 4'b1011);
        check("f1_epb", epb4, 1'b1);
        check("f1_busy", busy4, 1'b0);
        idle(100);
        check("f1_hold_nib", {d4, c4, b4, a4}, 4'b1011);
        check("f1_hold_epb", epb4, 1'b1);
        check("f1_hold_fv_cnt", fv4_cnt, 1);
        check("f1_hold_fe_cnt", fe4_cnt, 0);

        // Wrong parity passes straight through
        send(4, 4'b0001, 1'b0, 1'b1, 4);
        idle(10);
        check("f2_fv_cnt", fv4_cnt, 2);
        check("f2_nib", {d4, c4, b4, a4}, 4'b0001);
        check("f2_epb", epb4, 1'b0);
        check("f2_fe_cnt", fe4_cnt, 0);

        // Stop bit 0: error pulse only, outputs keep previous frame
        send(4, 4'b0110, 1'b0, 1'b0, 4);
        idle(12);
        check("f3_fe_cnt", fe4_cnt, 1);
        check("f3_fv_cnt", fv4_cnt, 2);
        check("f3_nib", {d4, c4, b4, a4}, 4'b0001);
        check("f3_epb", epb4, 1'b0);
        check("f3_busy", busy4, 1'b0);

        // Start glitch: one clock low
        busy_before = busy4_cnt;
        rxd4 = 1'b0;
        idle(1);
        rxd4 = 1'b1;
        idle(12);
        check("gl_busy_seen", (busy4_cnt > busy_before), 1'b1);
        check("gl_busy_drop", busy4, 1'b0);
        check("gl_fv_cnt", fv4_cnt, 2);
        check("gl_fe_cnt", fe4_cnt, 1);
        check("gl_nib", {d4, c4, b4, a4}, 4'b0001);
        check("both4_cnt", both4_cnt, 0);

        // Back-to-back frames at 16 clocks/bit
        send(16, 4'b1111, 1'b0, 1'b1, 16);
        send(16, 4'b0101, 1'b0, 1'b1, 16);
        idle(20);
        check("b2b_fv_cnt", fv16_cnt, 2);
        check("b2b_fe_cnt", fe16_cnt, 0);
        check("b2b_log0_nib", log_nib[0], 4'b1111);
        check("b2b_log0_par", log_par[0], 1'b0);
        check("b2b_log1_nib", log_nib[1], 4'b0101);
        check("b2b_log1_par", log_par[1], 1'b0);
        check("b2b_nib", {d16, c16, b16, a16}, 4'b0101);
        check("b2b_busy", busy16, 1'b0);

        // Third frame abandoned by reset after two data bits
        drive_bits(16, 7'b0000010, 3, 16);
        check("mid_busy16", busy16, 1'b1);
        rst = 1'b1;
        rxd16 = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(40);
        check("mid_fv_cnt", fv16_cnt, 2);
        check("mid_fe_cnt", fe16_cnt, 0);
        check("mid_nib16", {d16, c16, b16, a16}, 4'h0);
        check("mid_epb16", epb16, 1'b0);
        check("mid_busy16_after", busy16, 1'b0);
        check("mid_nib4", {d4, c4, b4, a4}, 4'h0);
        check("both16_cnt", both16_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
